sr_latch_driver: RTL and testbench

- Synchronous controller that drives the s/r inputs of a NOR-based SR latch and confirms the result by reading back q.
- Turns a level request (valid/ready) into a single clean set or reset pulse of fixed width, then a gap, then a readback check with timeout.
- Guarantees s and r are never high together, which is the forbidden NOR-latch input.
- Sits between lab control logic and any cross-coupled NOR latch cell.

---
 rtl/sr_latch_driver.sv | 152 +++++++++++++++
 tb/tb_sr_latch_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Drives the s/r inputs of a NOR SR latch with one clean fixed-width pulse per request,
// then waits a gap and confirms the result by reading back q.
module sr_latch_driver #(
  parameter int unsigned PULSE_W  = 4,
  parameter int unsigned GAP_W    = 2,
  parameter int unsigned CHECK_TO = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic busy,
  output logic done,
  output logic err,
  output logic level
);

  localparam logic [7:0] PulseLd = 8'(PULSE_W - 1);
  localparam logic [7:0] GapLd   = 8'(GAP_W - 1);
  localparam logic [7:0] CheckLd = 8'(CHECK_TO - 1);

  typedef enum logic [2:0] {
    StInitPulse,
    StInitGap,
    StIdle,
    StPulse,
    StGap,
    StCheck
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       arm_q, arm_d;
  logic [1:0] sync_q;
  logic       q_sync;
  logic       s_d, r_d, ready_d, busy_d, done_d, err_d, level_d;

  assign q_sync = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    level_d = level;
    err_d   = err;
    done_d  = 1'b0;
    unique case (state_q)
      StInitPulse: begin
        // The first edge out of reset only loads the counter; r rises on that same edge.
        if (arm_q) begin
          arm_d = 1'b0;
          cnt_d = PulseLd;
        end else if (cnt_q == 8'd0) begin
          state_d = StInitGap;
          cnt_d   = GapLd;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StInitGap: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StIdle: begin
        if (req_valid && req_ready) begin
          state_d = StPulse;
          cnt_d   = PulseLd;
          level_d = req_level;
          err_d   = 1'b0;
        end
      end
      StPulse: begin
        if (cnt_q == 8'd0) begin
          state_d = StGap;
          cnt_d   = GapLd;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          state_d = StCheck;
          cnt_d   = CheckLd;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StCheck: begin
        if (q_sync == level) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = StInitPulse;
        cnt_d   = 8'd0;
        arm_d   = 1'b1;
      end
    endcase

    // Outputs are decoded from the next state so the registered pins line up with the state.
    s_d     = (state_d == StPulse) && level_d;
    r_d     = ((state_d == StPulse) && !level_d) || ((state_d == StInitPulse) && !arm_d);
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StInitPulse;
      cnt_q     <= 8'd0;
      arm_q     <= 1'b1;
      sync_q    <= 2'b00;
      s         <= 1'b0;
      r         <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      level     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arm_q     <= arm_d;
      sync_q    <= {sync_q[0], q_fb};
      s         <= s_d;
      r         <= r_d;
      req_ready <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      level     <= level_d;
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural NOR latch on s/r and an optional
// stuck-at-0 fault on the q feedback.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_level = 1'b0;
  logic req_ready, s, r, busy, done, err, level;
  logic q_fb;
  logic latch_q = 1'b0;
  logic stuck = 1'b0;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(s, r) begin
    if (s && !r) latch_q = 1'b1;
    else if (r && !s) latch_q = 1'b0;
  end

  assign q_fb = stuck ? 1'b0 : latch_q;

  always @(s, r) begin
    if (s && r) begin
      fails++;
      $display("FAIL s_and_r_high actual=1 required=0 time=%0t", $time);
    end
  end

  sr_latch_driver #(
    .PULSE_W (4),
    .GAP_W   (2),
    .CHECK_TO(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_level(req_level),
    .req_ready(req_ready),
    .s        (s),
    .r        (r),
    .q_fb     (q_fb),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .level    (level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Hold reset three cycles, release, then check the r pulse / gap / done timeline.
  task automatic init_seq();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s", s, 0);
    chk("rst_r", r, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_level", level, 0);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      chk("init_r", r, (k <= 4) ? 1 : 0);
      chk("init_s", s, 0);
      chk("init_done", done, (k == 7) ? 1 : 0);
      chk("init_ready", req_ready, (k == 7) ? 1 : 0);
      chk("init_busy", busy, (k == 7) ? 0 : 1);
    end
    chk("init_level", level, 0);
    chk("init_err", err, 0);
    chk("init_latch_q", latch_q, 0);
    @(posedge clk);
    #1;
    chk("init_done_width", done, 0);
    chk("init_ready_hold", req_ready, 1);
  endtask

  // One full command; lat is the cycle (counted from the accept edge) where done must appear.
  task automatic run_cmd(input logic lvl, input logic stk, input int lat, input logic exp_err);
    stuck = stk;
    chk("cmd_ready_before", req_ready, 1);
    req_valid = 1'b1;
    req_level = lvl;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_level = ~lvl;
    chk("cmd_err_cleared", err, 0);
    chk("cmd_level", level, lvl);
    for (int c = 0; c <= lat; c++) begin
      chk("cmd_s", s, (c < 4) ? lvl : 0);
      chk("cmd_r", r, (c < 4) ? !lvl : 0);
      chk("cmd_done", done, (c == lat) ? 1 : 0);
      chk("cmd_ready", req_ready, (c == lat) ? 1 : 0);
      if (c < lat) begin
        @(posedge clk);
        #1;
      end
    end
    chk("cmd_end_err", err, exp_err);
    chk("cmd_end_level", level, lvl);
    if (!stk) chk("cmd_latch_q", latch_q, lvl);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("idle_done", done, 0);
      chk("idle_err_sticky", err, exp_err);
      chk("idle_ready", req_ready, 1);
      chk("idle_busy", busy, 0);
    end
  endtask

  typedef struct {
    logic lvl;
    logic stk;
    int   lat;
    logic exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   accepts;
    int   dones;
    logic prev_ready;
    logic prev_lvl;
    logic exp_lvl;
    logic seen;

    vecs[0] = '{lvl: 1'b1, stk: 1'b0, lat: 7,  exp_err: 1'b0};  // set
    vecs[1] = '{lvl: 1'b0, stk: 1'b0, lat: 7,  exp_err: 1'b0};  // reset
    vecs[2] = '{lvl: 1'b0, stk: 1'b0, lat: 7,  exp_err: 1'b0};  // same level again
    vecs[3] = '{lvl: 1'b1, stk: 1'b1, lat: 14, exp_err: 1'b1};  // stuck feedback, timeout
    vecs[4] = '{lvl: 1'b0, stk: 1'b1, lat: 7,  exp_err: 1'b0};  // clears err; 0 still matches
    vecs[5] = '{lvl: 1'b1, stk: 1'b0, lat: 7,  exp_err: 1'b0};

    init_seq();
    for (int i = 0; i < 6; i++) run_cmd(vecs[i].lvl, vecs[i].stk, vecs[i].lat, vecs[i].exp_err);

    // Reset during the second s-high cycle must drop s with no clock edge.
    stuck = 1'b0;
    chk("mid_ready_before", req_ready, 1);
    req_valid = 1'b1;
    req_level = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_s_first", s, 1);
    @(posedge clk);
    #1;
    chk("mid_s_second", s, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_s_async", s, 0);
    chk("mid_r_async", r, 0);
    chk("mid_busy_async", busy, 1);
    chk("mid_ready_async", req_ready, 0);
    init_seq();

    // Back-to-back stress with req_valid held high.
    accepts = 0;
    dones = 0;
    exp_lvl = 1'b0;
    for (int i = 0; i < 500; i++) begin
      req_valid = 1'b1;
      req_level = 1'($urandom_range(1, 0));
      prev_ready = req_ready;
      prev_lvl = req_level;
      @(posedge clk);
      #1;
      if (prev_ready) begin
        accepts++;
        exp_lvl = prev_lvl;
        chk("stress_accept_level", level, exp_lvl);
        chk("stress_ready_drop", req_ready, 0);
      end
      chk("stress_ready_busy", req_ready, !busy);
      if (done) begin
        dones++;
        chk("stress_done_q", latch_q, level);
        chk("stress_done_level", level, exp_lvl);
        chk("stress_done_err", err, 0);
      end
    end
    chk("stress_accepts", accepts, 63);
    chk("stress_dones", dones, 62);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("stress_final_done", seen, 1);
    chk("stress_final_q", latch_q, exp_lvl);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
